// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end for the RV32I pipeline.
// Issues one blocking I-mem read at a time, buffers returned words with their
// PCs in a DEPTH-entry FIFO and hands them to ID over a valid/ready handshake.
// A redirect from EX flushes the FIFO and squashes any in-flight response.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   imem_read / imem_address    read request (held until imem_resp)
//   imem_resp / imem_rdata      one-cycle response strobe + instruction word
//   redirect / redirect_pc      one-cycle control-flow redirect from EX
//   id_valid / id_ready         head-entry handshake to ID
//   id_instr / id_pc            head instruction and its PC
//   count                       current FIFO occupancy
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0060)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_read,
  output logic [XLEN-1:0]            imem_address,
  input  logic                       imem_resp,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_instr,
  output logic [XLEN-1:0]            id_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] req_pc, req_pc_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic            enq, deq;
  logic [XLEN-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  assign imem_read    = (state != IDLE);
  assign imem_address = req_pc;
  assign id_valid     = (count != '0);
  // Gate with id_valid so the un-reset storage never shows through.
  assign id_instr     = id_valid ? fifo_q[rd_ptr].instr : '0;
  assign id_pc        = id_valid ? fifo_q[rd_ptr].pc    : '0;

  always_comb begin
    enq          = (state == REQ) && imem_resp && !redirect;
    deq          = id_valid && id_ready && !redirect;
    count_nxt    = count + CW'(enq) - CW'(deq);
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    if (redirect) fetch_pc_nxt = redirect_tgt;
    case (state)
      IDLE: begin
        // Issue only with a free slot, so an enqueue never meets a full FIFO.
        if (!redirect && count < FULL) begin
          state_nxt  = REQ;
          req_pc_nxt = fetch_pc;
        end
      end
      REQ: begin
        if (redirect) begin
          // Without a response the request is still in flight and its
          // eventual data must be swallowed.
          state_nxt = imem_resp ? IDLE : DISCARD;
        end else if (imem_resp) begin
          fetch_pc_nxt = req_pc + XLEN'(4);
          // Chain the next read immediately while room remains.
          if (count_nxt < FULL) req_pc_nxt = req_pc + XLEN'(4);
          else                  state_nxt  = IDLE;
        end
      end
      DISCARD: begin
        if (imem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count_nxt;
        if (enq) wr_ptr <= wr_ptr + PW'(1);
        if (deq) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr] <= '{pc: req_pc, instr: imem_rdata};
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  count;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0060)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural view as a queue of fetched entries plus
  // "a read is outstanding" / "its data is to be thrown away" flags.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  logic        m_busy, m_disc;
  logic [31:0] m_req, m_fetch;
  int          wcnt;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy = 1'b0; m_disc = 1'b0;
    m_req = 32'h60; m_fetch = 32'h60;
    wcnt = 0;
  endtask

  task automatic model_step(input logic resp, input logic [31:0] rdata,
                            input logic redir, input logic [31:0] rpc, input logic rdy);
    int sz0;
    sz0 = m_q.size();
    if (redir) begin
      m_q.delete();
      m_fetch = {rpc[31:2], 2'b00};
      if (m_busy) begin
        if (resp) begin m_busy = 1'b0; m_disc = 1'b0; end
        else m_disc = 1'b1;
      end
    end else begin
      if (sz0 != 0 && rdy) void'(m_q.pop_front());
      if (!m_busy) begin
        if (sz0 < DEPTH) begin m_busy = 1'b1; m_req = m_fetch; end
      end else if (m_disc) begin
        if (resp) begin m_busy = 1'b0; m_disc = 1'b0; end
      end else if (resp) begin
        m_q.push_back('{pc: m_req, instr: rdata});
        m_fetch = m_req + 32'd4;
        if (m_q.size() < DEPTH) m_req = m_req + 32'd4;
        else m_busy = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // return at the next falling edge with outputs settled.
  task automatic tick(input logic resp, input logic [31:0] rdata,
                      input logic redir, input logic [31:0] rpc, input logic rdy);
    imem_resp = resp; imem_rdata = rdata;
    redirect = redir; redirect_pc = rpc; id_ready = rdy;
    if (rst_n) model_step(resp, rdata, redir, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory that answers on the lat-th cycle of a request.
  task automatic mem_tick(input int lat, input logic redir, input logic [31:0] rpc,
                          input logic rdy);
    logic r;
    r = 1'b0;
    if (m_busy) begin
      wcnt++;
      if (wcnt >= lat) begin r = 1'b1; wcnt = 0; end
    end
    tick(r, memdata(m_req), redir, rpc, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (imem_read !== 1'b0) begin n_err++; $display("FAIL reset_read got %0b want 0", imem_read); end
    n_cmp++; if (imem_address !== 32'h60) begin n_err++; $display("FAIL reset_addr got %h want 00000060", imem_address); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", id_valid); end
    n_cmp++; if (id_instr !== 32'h0 || id_pc !== 32'h0) begin n_err++; $display("FAIL reset_head got %h/%h want 0/0", id_instr, id_pc); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_tick(1, 1'b0, '0, 1'b1);
    n_cmp++; if (imem_read !== 1'b1 || imem_address !== 32'h60) begin n_err++; $display("FAIL stream_first_req got %0b@%h want 1@00000060", imem_read, imem_address); end
    for (int i = 0; i < 6; i++) begin
      mem_tick(1, 1'b0, '0, 1'b1);
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h60 + 32'(4*i)) begin n_err++; $display("FAIL stream_pc[%0d] got %0b/%h want 1/%h", i, id_valid, id_pc, 32'h60 + 32'(4*i)); end
      n_cmp++; if (id_instr !== memdata(32'h60 + 32'(4*i))) begin n_err++; $display("FAIL stream_instr[%0d] got %h want %h", i, id_instr, memdata(32'h60 + 32'(4*i))); end
      n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL stream_count[%0d] got %0d want 1", i, count); end
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] e;
    do_reset();
    mem_tick(1, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      mem_tick(1, 1'b0, '0, 1'b0);
      n_cmp++; if (count !== 3'(i)) begin n_err++; $display("FAIL fill_count got %0d want %0d", count, i); end
    end
    n_cmp++; if (imem_read !== 1'b0) begin n_err++; $display("FAIL fill_idle got %0b want 0", imem_read); end
    mem_tick(1, 1'b0, '0, 1'b0);
    n_cmp++; if (imem_read !== 1'b0 || count !== 3'd4) begin n_err++; $display("FAIL fill_hold got %0b/%0d want 0/4", imem_read, count); end
    e = 32'h60;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== e) begin n_err++; $display("FAIL drain_pc[%0d] got %0b/%h want 1/%h", i, id_valid, id_pc, e); end
      n_cmp++; if (id_instr !== memdata(e)) begin n_err++; $display("FAIL drain_instr[%0d] got %h want %h", i, id_instr, memdata(e)); end
      mem_tick(1, 1'b0, '0, 1'b1);
      e = e + 32'd4;
      if (i == 1) begin
        n_cmp++; if (imem_read !== 1'b1 || imem_address !== 32'h70) begin n_err++; $display("FAIL drain_resume got %0b@%h want 1@00000070", imem_read, imem_address); end
      end
    end
  endtask

  task automatic test_redirect_latency();
    do_reset();
    for (int i = 0; i < 5; i++) mem_tick(3, 1'b0, '0, 1'b1);
    n_cmp++; if (imem_read !== 1'b1 || imem_address !== 32'h64) begin n_err++; $display("FAIL rdl_req64 got %0b@%h want 1@00000064", imem_read, imem_address); end
    mem_tick(3, 1'b1, 32'h200, 1'b1);
    n_cmp++; if (imem_read !== 1'b1 || imem_address !== 32'h64 || count !== 3'd0) begin n_err++; $display("FAIL rdl_discard got %0b@%h cnt %0d want 1@00000064 cnt 0", imem_read, imem_address, count); end
    mem_tick(3, 1'b0, '0, 1'b1);
    n_cmp++; if (imem_read !== 1'b0 || id_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL rdl_dropped got %0b/%0b/%0d want 0/0/0", imem_read, id_valid, count); end
    mem_tick(3, 1'b0, '0, 1'b1);
    n_cmp++; if (imem_read !== 1'b1 || imem_address !== 32'h200) begin n_err++; $display("FAIL rdl_target got %0b@%h want 1@00000200", imem_read, imem_address); end
    for (int i = 0; i < 3; i++) mem_tick(3, 1'b0, '0, 1'b0);
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== memdata(32'h200)) begin n_err++; $display("FAIL rdl_first got %0b/%h/%h want 1/00000200/%h", id_valid, id_pc, id_instr, memdata(32'h200)); end
  endtask

  task automatic test_redirect_hs();
    do_reset();
    for (int i = 0; i < 3; i++) mem_tick(1, 1'b0, '0, 1'b0);
    n_cmp++; if (count !== 3'd2 || imem_read !== 1'b1) begin n_err++; $display("FAIL rhs_setup got %0d/%0b want 2/1", count, imem_read); end
    tick(1'b1, memdata(32'h68), 1'b1, 32'h103, 1'b1);
    n_cmp++; if (count !== 3'd0 || id_valid !== 1'b0 || imem_read !== 1'b0) begin n_err++; $display("FAIL rhs_flush got %0d/%0b/%0b want 0/0/0", count, id_valid, imem_read); end
    mem_tick(1, 1'b0, '0, 1'b1);
    n_cmp++; if (imem_read !== 1'b1 || imem_address !== 32'h100) begin n_err++; $display("FAIL rhs_target got %0b@%h want 1@00000100", imem_read, imem_address); end
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    mem_tick(1, 1'b1, 32'h74, 1'b0);
    for (int i = 0; i < 4; i++) mem_tick(1, 1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0, '0, 1'b0);
    n_cmp++; if (imem_read !== 1'b1 || imem_address !== 32'h80 || count !== 3'd3) begin n_err++; $display("FAIL rmr_setup got %0b@%h cnt %0d want 1@00000080 cnt 3", imem_read, imem_address, count); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (imem_read !== 1'b0 || id_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL rmr_async got %0b/%0b/%0d want 0/0/0", imem_read, id_valid, count); end
    @(negedge clk);
    tick(1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    tick(1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    n_cmp++; if (imem_read !== 1'b1 || imem_address !== 32'h60 || count !== 3'd0 || id_valid !== 1'b0) begin n_err++; $display("FAIL rmr_restart got %0b@%h cnt %0d v %0b want 1@00000060 cnt 0 v 0", imem_read, imem_address, count, id_valid); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] e;
    do_reset();
    mem_tick(1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    mem_tick(1, 1'b0, '0, 1'b1);
    e = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      mem_tick(1, 1'b0, '0, 1'b1);
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== e) begin n_err++; $display("FAIL wrap_pc[%0d] got %0b/%h want 1/%h", i, id_valid, id_pc, e); end
      e = e + 32'd4;
    end
  endtask

  task automatic test_random();
    logic        r, rd, rdy;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] ei, ep;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rd  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      rdy = ($urandom_range(0, 9) < 7);
      r   = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      tick(r, $urandom, rd, rpc, rdy);
      ev = (m_q.size() != 0);
      ei = ev ? m_q[0].instr : 32'h0;
      ep = ev ? m_q[0].pc : 32'h0;
      n_cmp++; if (imem_read !== m_busy) begin n_err++; $display("FAIL rnd_read@%0d got %0b want %0b", c, imem_read, m_busy); end
      n_cmp++; if (imem_address !== m_req) begin n_err++; $display("FAIL rnd_addr@%0d got %h want %h", c, imem_address, m_req); end
      n_cmp++; if (count !== 3'(m_q.size())) begin n_err++; $display("FAIL rnd_count@%0d got %0d want %0d", c, count, m_q.size()); end
      n_cmp++; if (id_valid !== ev) begin n_err++; $display("FAIL rnd_valid@%0d got %0b want %0b", c, id_valid, ev); end
      n_cmp++; if (id_pc !== ep || id_instr !== ei) begin n_err++; $display("FAIL rnd_head@%0d got %h/%h want %h/%h", c, id_pc, id_instr, ep, ei); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_fill_drain();
    test_redirect_latency();
    test_redirect_hs();
    test_reset_mid_req();
    test_pc_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
